// File: rtl/writeback.sv
// Writeback stage: one capture register feeding the register-file write port, load extraction and misalign pulse.
// Optional retire counter output wb_retire_cnt_out is built when WB_RETIRE_CNT_EN is defined.
module writeback #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid_in,
    input  logic            wb_reg_wr_in,
    input  logic [4:0]      wb_rd_in,
    input  logic [1:0]      wb_reg_in_sel_in,
    input  logic [2:0]      wb_func3_in,
    input  logic [XLEN-1:0] wb_alu_in,
    input  logic [XLEN-1:0] wb_drdata_in,
    input  logic [XLEN-1:0] wb_pc_in,
    input  logic [XLEN-1:0] wb_imm_in,
    input  logic            wb_stall_in,
    input  logic            wb_flush_in,
    output logic            wb_reg_wr_out,
    output logic [4:0]      wb_rd_out,
    output logic [XLEN-1:0] wb_reg_data_out,
`ifdef WB_RETIRE_CNT_EN
    output logic [XLEN-1:0] wb_retire_cnt_out,
`endif
    output logic            wb_misalign_out
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic            vld_p0;
    logic            reg_wr_p0;
    logic            done_p0;
    logic [4:0]      rd_p0;
    logic [1:0]      sel_p0;
    logic [2:0]      func3_p0;
    logic [XLEN-1:0] alu_p0;
    logic [XLEN-1:0] drdata_p0;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] imm_p0;

    logic            is_load;
    logic            mis;

    // func3[1:0]: 00 byte, 01 halfword, anything else behaves as a word access
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [XLEN-1:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            2'b01:   return f3[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // ---- stage p0: capture register (stall holds, flush clears valid only) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            reg_wr_p0 <= 1'b0;
            done_p0   <= 1'b0;
            rd_p0     <= '0;
            sel_p0    <= '0;
            func3_p0  <= '0;
            alu_p0    <= '0;
            drdata_p0 <= '0;
            pc_p0     <= '0;
            imm_p0    <= '0;
        end else if (wb_stall_in) begin
            // The held instruction has already had its one cycle on the write port.
            done_p0   <= 1'b1;
        end else begin
            vld_p0    <= wb_valid_in & ~wb_flush_in;
            reg_wr_p0 <= wb_reg_wr_in;
            done_p0   <= 1'b0;
            rd_p0     <= wb_rd_in;
            sel_p0    <= wb_reg_in_sel_in;
            func3_p0  <= wb_func3_in;
            alu_p0    <= wb_alu_in;
            drdata_p0 <= wb_drdata_in;
            pc_p0     <= wb_pc_in;
            imm_p0    <= wb_imm_in;
        end
    end

    assign is_load = (sel_p0 == SEL_LOAD);
    assign mis     = is_load & misaligned(func3_p0, alu_p0[1:0]);

    assign wb_reg_wr_out   = vld_p0 & reg_wr_p0 & (rd_p0 != 5'd0) & ~mis & ~done_p0;
    assign wb_misalign_out = vld_p0 & mis & ~done_p0;
    assign wb_rd_out       = rd_p0;

    always_comb begin
        wb_reg_data_out = imm_p0;
        case (sel_p0)
            SEL_ALU:  wb_reg_data_out = alu_p0;
            SEL_LOAD: wb_reg_data_out = load_extract(func3_p0, alu_p0[1:0], drdata_p0);
            SEL_PC4:  wb_reg_data_out = pc_p0 + XLEN'(4);
            default:  wb_reg_data_out = imm_p0;
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    logic [XLEN-1:0] retire_cnt;

    // An instruction retires on the edge it is replaced, so stalls never count it twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (!wb_stall_in && vld_p0) begin
            retire_cnt <= retire_cnt + XLEN'(1);
        end
    end

    assign wb_retire_cnt_out = retire_cnt;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: table of single-cycle vectors plus stall/flush/reset sequences.
module tb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, reg_wr_i, stall_i, flush_i;
    logic [4:0]  rd_i;
    logic [1:0]  sel_i;
    logic [2:0]  f3_i;
    logic [31:0] alu_i, dr_i, pc_i, imm_i;
    logic        wr_o, mis_o;
    logic [4:0]  rd_o;
    logic [31:0] data_o;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_o;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic held_vld = 1'b0;

    always #5 clk = ~clk;

    writeback #(.XLEN(32)) dut (
        .clk(clk),
        .reset(reset),
        .wb_valid_in(valid_i),
        .wb_reg_wr_in(reg_wr_i),
        .wb_rd_in(rd_i),
        .wb_reg_in_sel_in(sel_i),
        .wb_func3_in(f3_i),
        .wb_alu_in(alu_i),
        .wb_drdata_in(dr_i),
        .wb_pc_in(pc_i),
        .wb_imm_in(imm_i),
        .wb_stall_in(stall_i),
        .wb_flush_in(flush_i),
        .wb_reg_wr_out(wr_o),
        .wb_rd_out(rd_o),
        .wb_reg_data_out(data_o),
`ifdef WB_RETIRE_CNT_EN
        .wb_retire_cnt_out(cnt_o),
`endif
        .wb_misalign_out(mis_o)
    );

    typedef struct {
        logic        vld, wr, flush;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu, dr, pc, imm;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic        chk_data;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic vld, wr, flush, input logic [4:0] rd, input logic [1:0] sel,
                                input logic [2:0] f3, input logic [31:0] alu, dr, pc, imm,
                                input logic e_wr, input logic [4:0] e_rd, input logic chk,
                                input logic [31:0] e_data, input logic e_mis);
        vec_t v;
        v.vld = vld; v.wr = wr; v.flush = flush; v.rd = rd; v.sel = sel; v.f3 = f3;
        v.alu = alu; v.dr = dr; v.pc = pc; v.imm = imm;
        v.e_wr = e_wr; v.e_rd = e_rd; v.chk_data = chk; v.e_data = e_data; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef WB_RETIRE_CNT_EN
        chk(name, cnt_o, exp_cnt);
`endif
    endtask

    task automatic drive(input vec_t v);
        valid_i = v.vld; reg_wr_i = v.wr; flush_i = v.flush; rd_i = v.rd; sel_i = v.sel;
        f3_i = v.f3; alu_i = v.alu; dr_i = v.dr; pc_i = v.pc; imm_i = v.imm;
    endtask

    // Advance one clock while tracking how many valid instructions have left the stage.
    task automatic tick();
        if (reset) begin
            exp_cnt = 0;
            held_vld = 1'b0;
        end else if (!stall_i) begin
            if (held_vld) exp_cnt++;
            held_vld = valid_i & ~flush_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(mk(0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 0));
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0;
        nop();
        tick();
        tick();
        chk("reset_wr", {31'b0, wr_o}, 32'h0);
        chk("reset_rd", {27'b0, rd_o}, 32'h0);
        chk("reset_data", data_o, 32'h0);
        chk("reset_mis", {31'b0, mis_o}, 32'h0);
        chk_cnt("reset_cnt");
        reset = 1'b0;

        vecs[0]  = mk(1, 1, 0, 5'd5,  2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h0, 1, 5'd5, 1, 32'h00001234, 0);
        vecs[1]  = mk(1, 1, 0, 5'd3,  2'b01, 3'b000, 32'h103, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd3, 1, 32'hFFFFFF80, 0);
        vecs[2]  = mk(1, 1, 0, 5'd3,  2'b01, 3'b100, 32'h103, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd3, 1, 32'h00000080, 0);
        vecs[3]  = mk(1, 1, 0, 5'd3,  2'b01, 3'b101, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd3, 1, 32'h000080FF, 0);
        vecs[4]  = mk(1, 1, 0, 5'd4,  2'b01, 3'b001, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd4, 1, 32'hFFFF80FF, 0);
        vecs[5]  = mk(1, 1, 0, 5'd4,  2'b01, 3'b001, 32'h100, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd4, 1, 32'h00007F01, 0);
        vecs[6]  = mk(1, 1, 0, 5'd6,  2'b01, 3'b000, 32'h101, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd6, 1, 32'h0000007F, 0);
        vecs[7]  = mk(1, 1, 0, 5'd6,  2'b01, 3'b100, 32'h100, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd6, 1, 32'h00000001, 0);
        vecs[8]  = mk(1, 1, 0, 5'd8,  2'b01, 3'b010, 32'h100, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd8, 1, 32'h80FF7F01, 0);
        vecs[9]  = mk(1, 1, 0, 5'd8,  2'b01, 3'b010, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 0, 5'd8, 0, 32'h0, 1);
        vecs[10] = mk(1, 1, 0, 5'd9,  2'b01, 3'b101, 32'h103, 32'h80FF7F01, 32'h0, 32'h0, 0, 5'd9, 0, 32'h0, 1);
        vecs[11] = mk(1, 1, 0, 5'd9,  2'b01, 3'b011, 32'h101, 32'h80FF7F01, 32'h0, 32'h0, 0, 5'd9, 0, 32'h0, 1);
        vecs[12] = mk(1, 1, 0, 5'd11, 2'b01, 3'b110, 32'h104, 32'h80FF7F01, 32'h0, 32'h0, 1, 5'd11, 1, 32'h80FF7F01, 0);
        vecs[13] = mk(1, 1, 0, 5'd1,  2'b10, 3'b000, 32'h0, 32'h0, 32'h200, 32'h0, 1, 5'd1, 1, 32'h00000204, 0);
        vecs[14] = mk(1, 1, 0, 5'd2,  2'b10, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 1, 5'd2, 1, 32'h00000000, 0);
        vecs[15] = mk(1, 1, 0, 5'd10, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0, 32'hDEADB000, 1, 5'd10, 1, 32'hDEADB000, 0);
        vecs[16] = mk(1, 1, 1, 5'd7,  2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0, 0, 5'd7, 1, 32'h00000077, 0);
        vecs[17] = mk(1, 1, 0, 5'd0,  2'b00, 3'b000, 32'h99, 32'h0, 32'h0, 32'h0, 0, 5'd0, 1, 32'h00000099, 0);
        vecs[18] = mk(1, 0, 0, 5'd4,  2'b00, 3'b000, 32'h42, 32'h0, 32'h0, 32'h0, 0, 5'd4, 1, 32'h00000042, 0);
        vecs[19] = mk(0, 1, 0, 5'd12, 2'b01, 3'b010, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 0, 5'd12, 0, 32'h0, 0);
        vecs[20] = mk(1, 1, 1, 5'd13, 2'b01, 3'b010, 32'h101, 32'h80FF7F01, 32'h0, 32'h0, 0, 5'd13, 0, 32'h0, 0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d_wr", i), {31'b0, wr_o}, {31'b0, vecs[i].e_wr});
            chk($sformatf("v%0d_rd", i), {27'b0, rd_o}, {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_mis", i), {31'b0, mis_o}, {31'b0, vecs[i].e_mis});
            if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), data_o, vecs[i].e_data);
        end
        nop();
        tick();
        chk_cnt("table_cnt");

        // Misaligned LW held by a 3-cycle stall: exactly one pulse.
        drive(mk(1, 1, 0, 5'd3, 2'b01, 3'b010, 32'h102, 32'h80FF7F01, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 0));
        tick();
        chk("mis_first", {31'b0, mis_o}, 32'h1);
        chk("mis_first_wr", {31'b0, wr_o}, 32'h0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mis_held%0d", i), {31'b0, mis_o}, 32'h0);
        end
        stall_i = 1'b0;
        nop();
        tick();
        chk("mis_after", {31'b0, mis_o}, 32'h0);
        chk_cnt("mis_cnt");

        // JAL held by a 4-cycle stall while inputs change: one write, data held.
        drive(mk(1, 1, 0, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h200, 32'h0, 0, 5'd0, 0, 32'h0, 0));
        tick();
        chk("jal_wr", {31'b0, wr_o}, 32'h1);
        chk("jal_data", data_o, 32'h204);
        stall_i = 1'b1;
        drive(mk(1, 1, 0, 5'd9, 2'b00, 3'b000, 32'hAAAA, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("jal_held%0d_wr", i), {31'b0, wr_o}, 32'h0);
            chk($sformatf("jal_held%0d_rd", i), {27'b0, rd_o}, 32'h1);
            chk($sformatf("jal_held%0d_data", i), data_o, 32'h204);
        end
        chk_cnt("jal_cnt_held");
        stall_i = 1'b0;
        nop();
        tick();
        chk("jal_after_wr", {31'b0, wr_o}, 32'h0);
        chk_cnt("jal_cnt_retired");

        // Stall outranks flush: held instruction keeps its fields.
        drive(mk(1, 1, 0, 5'd6, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 0));
        tick();
        chk("sf_wr", {31'b0, wr_o}, 32'h1);
        stall_i = 1'b1;
        drive(mk(1, 1, 1, 5'd14, 2'b00, 3'b000, 32'h66, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 0));
        tick();
        chk("sf_rd", {27'b0, rd_o}, 32'h6);
        chk("sf_data", data_o, 32'h55);
        stall_i = 1'b0;
        nop();
        tick();

        // Reset during a stall discards the held instruction.
        drive(mk(1, 1, 0, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 0));
        tick();
        stall_i = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_stall_wr", {31'b0, wr_o}, 32'h0);
        chk("rst_stall_rd", {27'b0, rd_o}, 32'h0);
        chk("rst_stall_data", data_o, 32'h0);
        chk("rst_stall_mis", {31'b0, mis_o}, 32'h0);
        chk_cnt("rst_stall_cnt");
        reset = 1'b0;
        tick();
        chk("post_rst_wr", {31'b0, wr_o}, 32'h0);
        stall_i = 1'b0;
        nop();
        tick();
        chk_cnt("post_rst_cnt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
